fetch_ras: RTL and testbench
============================

// Module: fetch_ras
// PURPOSE
//  Return address stack for the fetch unit. Sits immediately downstream of the F1 branch
//  decoder. Consumes its RAS control/data and supplies the predicted return target
//  (ras_pcdata_f0_o) back to the decoder and the F0 next-PC select.
//  The stack is circular with an occupancy counter.
//  Per-bundle checkpoints (ptr/cnt) are exported so the backend can repair the stack on flush.
// PARAMETERS
//  DEPTH  8  number of entries (power of two, >=2)
//  PTR_W  3  pointer width = log2(DEPTH)
//  CNT_W  4  occupancy counter width = log2(DEPTH)+1
// PORTS
//  clk_i             in   1      core clock
//  rst_i             in   1      asynchronous active-high reset
//  f1_vld_i          in   1      F1 bundle valid and advancing this cycle (not stalled)
//  brdec_brext_f1_i  in   1      F1 bundle contains a branch
//  brdec_rasctl_f1_i in   2      00 none, 01 push, 10 pop, 11 pop-then-push
//  brdec_rasdat_f1_i in   64     PC of the branch instruction; return addr = this + 4
//  flush_vld_i       in   1      backend redirect; restore checkpoint this cycle
//  flush_rasptr_i    in   PTR_W  pointer value to restore
//  flush_rascnt_i    in   CNT_W  occupancy to restore (0..DEPTH)
//  flush_rastos_i    in   64     correct top-of-stack value at the flush point
//  ras_pcdata_f0_o   out  64     predicted return target (current TOS)
//  ras_ptr_f1_o      out  PTR_W  checkpoint: pointer before this cycle's update
//  ras_cnt_f1_o      out  CNT_W  checkpoint: occupancy before this cycle's update
//  ras_empty_o       out  1      cnt == 0
//  ras_ovf_o         out  1      1-cycle pulse: push issued while cnt == DEPTH
// BEHAVIOUR
//  - Reset (async, rst_i=1): ptr=0, cnt=0, all entries=0, ras_ovf_o=0, ras_pcdata_f0_o=0,
//    ras_empty_o=1. Reset mid-operation discards all state immediately.
//  - op_en = f1_vld_i & brdec_brext_f1_i & ~flush_vld_i. When op_en=0, the stack holds
//    regardless of rasctl.
//  - ret = brdec_rasdat_f1_i + 64'h4, modulo 2^64 (carry out dropped).
//  - Push (01): ptr <= ptr+1 mod DEPTH; stack[ptr+1] <= ret; cnt <= min(cnt+1, DEPTH).
//    At cnt == DEPTH the oldest entry is overwritten and ras_ovf_o pulses next cycle.
//  - Pop (10), cnt > 0: ptr <= ptr-1 mod DEPTH; cnt <= cnt-1.
//    Pop at cnt == 0: no state change (underflow ignored).
//  - Pop-then-push (11): stack[ptr] <= ret; ptr unchanged; cnt <= max(cnt, 1).
//  - Flush (priority over any op in the same cycle): ptr <= flush_rasptr_i;
//    cnt <= flush_rascnt_i; stack[flush_rasptr_i] <= flush_rastos_i; ras_ovf_o <= 0.
//  - All state updates at posedge clk_i; a new TOS is visible on ras_pcdata_f0_o the
//    cycle after the op (1-cycle latency).
//  - ras_pcdata_f0_o = (cnt == 0) ? 64'h0 : stack[ptr], combinational from registers.
//  - ras_ptr_f1_o / ras_cnt_f1_o are combinational copies of the current ptr/cnt
//    (pre-update). Fetch attaches them to the F1 bundle for later repair.
//  - Single-ported write: at most one entry is written per cycle.
// TESTING
//  1. Assert rst_i mid-sequence after 3 pushes -> immediately ras_pcdata_f0_o=0,
//     ras_empty_o=1, ras_ptr_f1_o=0, ras_cnt_f1_o=0.
//  2. Push with rasdat=0x1000 -> next cycle ras_pcdata_f0_o=0x1004, cnt=1; then pop ->
//     ras_empty_o=1, ras_pcdata_f0_o=0.
//  3. DEPTH=8: push k*0x100 for k=1..9 -> ras_ovf_o pulses once after 9th, cnt=8;
//     8 pops yield 0x904,0x804,...,0x204, then empty; extra pop leaves ptr/cnt unchanged.
//  4. cnt=2, TOS=0x2004, op 11 with rasdat=0x3000 -> TOS=0x3004, cnt=2, ptr unchanged;
//     pop -> previous entry returns.
//  5. Flush with ptr=5, cnt=3, tos=0xABC0 in same cycle as push -> push ignored;
//     next cycle ras_pcdata_f0_o=0xABC0, ras_ptr_f1_o=5, ras_cnt_f1_o=3.
//  6. rasctl=01 with brext=0 or f1_vld_i=0 -> no change.
//     Push rasdat=0xFFFF_FFFF_FFFF_FFFC -> TOS=0.

Source files
------------

// File: rtl/fetch_ras.sv
// -----------------------------------------------------------------------------
// fetch_ras -- circular return address stack for the fetch unit.
//
// This block sits downstream of the F1 branch decoder. It takes the decoder's
// RAS control and branch PC, and it supplies the predicted return target (the
// current top of stack) to the decoder and to the F0 next-PC select. An
// occupancy counter tracks how many entries are valid. The block exports a
// checkpoint (ptr/cnt) with each bundle so the backend can restore the stack on
// a flush.
//
// Ports
//   clk_i             in   1      core clock
//   rst_i             in   1      asynchronous active-high reset
//   f1_vld_i          in   1      F1 bundle valid and advancing this cycle
//   brdec_brext_f1_i  in   1      F1 bundle contains a branch
//   brdec_rasctl_f1_i in   2      00 none, 01 push, 10 pop, 11 pop-then-push
//   brdec_rasdat_f1_i in   64     branch PC; the pushed return address is PC+4
//   flush_vld_i       in   1      backend redirect; restore checkpoint now
//   flush_rasptr_i    in   PTR_W  pointer to restore
//   flush_rascnt_i    in   CNT_W  occupancy to restore (0..DEPTH)
//   flush_rastos_i    in   64     correct top-of-stack value at the flush point
//   ras_pcdata_f0_o   out  64     predicted return target (0 when empty)
//   ras_ptr_f1_o      out  PTR_W  checkpoint: pointer before this cycle's update
//   ras_cnt_f1_o      out  CNT_W  checkpoint: occupancy before this cycle's update
//   ras_empty_o       out  1      occupancy is zero
//   ras_ovf_o         out  1      one-cycle pulse after a push into a full stack
// -----------------------------------------------------------------------------
module fetch_ras #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             f1_vld_i,
   input  logic             brdec_brext_f1_i,
   input  logic [1:0]       brdec_rasctl_f1_i,
   input  logic [63:0]      brdec_rasdat_f1_i,
   input  logic             flush_vld_i,
   input  logic [PTR_W-1:0] flush_rasptr_i,
   input  logic [CNT_W-1:0] flush_rascnt_i,
   input  logic [63:0]      flush_rastos_i,
   output logic [63:0]      ras_pcdata_f0_o,
   output logic [PTR_W-1:0] ras_ptr_f1_o,
   output logic [CNT_W-1:0] ras_cnt_f1_o,
   output logic             ras_empty_o,
   output logic             ras_ovf_o
);

   typedef enum logic [1:0] {
      RAS_NONE    = 2'b00,
      RAS_PUSH    = 2'b01,
      RAS_POP     = 2'b10,
      RAS_POPPUSH = 2'b11
   } ras_op_e;

   logic [63:0]      stack [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] cnt;

   logic             op_en;
   ras_op_e          op;
   logic [63:0]      ret_addr;
   logic             full;
   logic             empty;

   logic [PTR_W-1:0] ptr_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic [63:0]      wr_data;

   assign op_en    = f1_vld_i & brdec_brext_f1_i & ~flush_vld_i;
   assign op       = ras_op_e'(brdec_rasctl_f1_i);
   assign ret_addr = brdec_rasdat_f1_i + 64'h4;
   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);

   // Next-state logic. All writes go through one port (wr_en/wr_idx/wr_data),
   // so a flush and a stack operation never both write an entry in one cycle.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave a value
      // unassigned and infer a latch.
      ptr_nxt = ptr;
      cnt_nxt = cnt;
      ovf_nxt = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = ptr;
      wr_data = ret_addr;

      if (flush_vld_i) begin
         // A flush takes priority over the bundle's own operation.
         ptr_nxt = flush_rasptr_i;
         cnt_nxt = flush_rascnt_i;
         wr_en   = 1'b1;
         wr_idx  = flush_rasptr_i;
         wr_data = flush_rastos_i;
      end else if (op_en) begin
         unique case (op)
            RAS_PUSH: begin
               ptr_nxt = ptr + PTR_W'(1);
               wr_en   = 1'b1;
               wr_idx  = ptr + PTR_W'(1);
               // When the stack is full, the push wraps onto the oldest entry.
               cnt_nxt = full ? cnt : cnt + CNT_W'(1);
               ovf_nxt = full;
            end
            RAS_POP: begin
               // A pop on an empty stack (underflow) is ignored.
               if (!empty) begin
                  ptr_nxt = ptr - PTR_W'(1);
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            RAS_POPPUSH: begin
               // A return followed by a call replaces the top entry in place.
               wr_en   = 1'b1;
               wr_idx  = ptr;
               cnt_nxt = empty ? CNT_W'(1) : cnt;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the entry array is reset together with the pointers so that a flush
   // to a nonzero occupancy right after reset never exposes X entries.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples the values computed before this edge.
         ptr       <= '0;
         cnt       <= '0;
         ras_ovf_o <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stack[i] <= '0;
         end
      end else begin
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         ras_ovf_o <= ovf_nxt;
         if (wr_en) begin
            stack[wr_idx] <= wr_data;
         end
      end
   end

   assign ras_pcdata_f0_o = empty ? 64'h0 : stack[ptr];
   assign ras_ptr_f1_o    = ptr;
   assign ras_cnt_f1_o    = cnt;
   assign ras_empty_o     = empty;

endmodule

// File: tb/tb_fetch_ras.sv
// -----------------------------------------------------------------------------
// tb_fetch_ras -- self-checking bench for fetch_ras.
//
// A reference model keeps the stack as an integer-indexed array with a modular
// top index and an occupancy count. Every cycle, all five DUT outputs are
// compared against the model. Directed sequences also check literal values,
// and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_fetch_ras;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;
   localparam int CNT_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             f1_vld_i;
   logic             brdec_brext_f1_i;
   logic [1:0]       brdec_rasctl_f1_i;
   logic [63:0]      brdec_rasdat_f1_i;
   logic             flush_vld_i;
   logic [PTR_W-1:0] flush_rasptr_i;
   logic [CNT_W-1:0] flush_rascnt_i;
   logic [63:0]      flush_rastos_i;
   logic [63:0]      ras_pcdata_f0_o;
   logic [PTR_W-1:0] ras_ptr_f1_o;
   logic [CNT_W-1:0] ras_cnt_f1_o;
   logic             ras_empty_o;
   logic             ras_ovf_o;

   fetch_ras #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .f1_vld_i          (f1_vld_i),
      .brdec_brext_f1_i  (brdec_brext_f1_i),
      .brdec_rasctl_f1_i (brdec_rasctl_f1_i),
      .brdec_rasdat_f1_i (brdec_rasdat_f1_i),
      .flush_vld_i       (flush_vld_i),
      .flush_rasptr_i    (flush_rasptr_i),
      .flush_rascnt_i    (flush_rascnt_i),
      .flush_rastos_i    (flush_rastos_i),
      .ras_pcdata_f0_o   (ras_pcdata_f0_o),
      .ras_ptr_f1_o      (ras_ptr_f1_o),
      .ras_cnt_f1_o      (ras_cnt_f1_o),
      .ras_empty_o       (ras_empty_o),
      .ras_ovf_o         (ras_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [63:0] m_mem [DEPTH];
   int          m_top;
   int          m_cnt;
   bit          m_ovf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_tos();
      return (m_cnt == 0) ? 64'h0 : m_mem[m_top];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'h0;
      m_top = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".tos"},   ras_pcdata_f0_o,      m_tos());
      check({tag, ".ptr"},   64'(ras_ptr_f1_o),    64'(m_top));
      check({tag, ".cnt"},   64'(ras_cnt_f1_o),    64'(m_cnt));
      check({tag, ".empty"}, 64'(ras_empty_o),     64'(m_cnt == 0));
      check({tag, ".ovf"},   64'(ras_ovf_o),       64'(m_ovf));
   endtask

   // Model semantics from the stack rules: a flush restores a checkpoint;
   // otherwise a valid branch pushes, pops, or replaces the top entry.
   task automatic model_update(input bit vld, input bit brext, input int ctl,
                               input logic [63:0] dat, input bit fl, input int fptr,
                               input int fcnt, input logic [63:0] ftos);
      m_ovf = 1'b0;
      if (fl) begin
         m_top        = fptr;
         m_cnt        = fcnt;
         m_mem[fptr]  = ftos;
      end else if (vld && brext) begin
         case (ctl)
            1: begin
               m_ovf        = (m_cnt == DEPTH);
               m_top        = (m_top + 1) % DEPTH;
               m_mem[m_top] = dat + 64'd4;
               if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
            end
            2: begin
               if (m_cnt > 0) begin
                  m_top = (m_top + DEPTH - 1) % DEPTH;
                  m_cnt = m_cnt - 1;
               end
            end
            3: begin
               m_mem[m_top] = dat + 64'd4;
               if (m_cnt == 0) m_cnt = 1;
            end
            default: ;
         endcase
      end
   endtask

   // Apply one cycle: drive inputs, clock, update the model, then sample 1ns
   // after the edge.
   task automatic step(input string tag, input bit vld, input bit brext, input int ctl,
                       input logic [63:0] dat, input bit fl, input int fptr,
                       input int fcnt, input logic [63:0] ftos);
      f1_vld_i          = vld;
      brdec_brext_f1_i  = brext;
      brdec_rasctl_f1_i = 2'(ctl);
      brdec_rasdat_f1_i = dat;
      flush_vld_i       = fl;
      flush_rasptr_i    = PTR_W'(fptr);
      flush_rascnt_i    = CNT_W'(fcnt);
      flush_rastos_i    = ftos;
      @(posedge clk_i);
      model_update(vld, brext, ctl, dat, fl, fptr, fcnt, ftos);
      #1;
      check_all(tag);
   endtask

   task automatic push(input string tag, input logic [63:0] dat);
      step(tag, 1'b1, 1'b1, 1, dat, 1'b0, 0, 0, 64'h0);
   endtask

   task automatic pop(input string tag);
      step(tag, 1'b1, 1'b1, 2, 64'h0, 1'b0, 0, 0, 64'h0);
   endtask

   // Asynchronous reset pulse, applied between clock edges.
   task automatic async_reset(input string tag);
      rst_i = 1'b1;
      #2;
      model_reset();
      check_all(tag);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      logic [PTR_W-1:0] ptr_save;
      logic [CNT_W-1:0] cnt_save;

      rst_i = 1'b1;
      f1_vld_i = 1'b0; brdec_brext_f1_i = 1'b0; brdec_rasctl_f1_i = 2'b00;
      brdec_rasdat_f1_i = '0; flush_vld_i = 1'b0; flush_rasptr_i = '0;
      flush_rascnt_i = '0; flush_rastos_i = '0;
      model_reset();
      #3;
      check_all("por");
      #9;
      rst_i = 1'b0;

      // Mid-sequence reset discards state immediately.
      push("t1.push", 64'h100);
      push("t1.push", 64'h200);
      push("t1.push", 64'h300);
      check("t1.pre_tos", ras_pcdata_f0_o, 64'h304);
      async_reset("t1.rst");
      check("t1.tos0", ras_pcdata_f0_o, 64'h0);
      check("t1.empty", 64'(ras_empty_o), 64'h1);
      check("t1.cnt0", 64'(ras_cnt_f1_o), 64'h0);

      // One push followed by one pop.
      push("t2.push", 64'h1000);
      check("t2.tos", ras_pcdata_f0_o, 64'h1004);
      check("t2.cnt", 64'(ras_cnt_f1_o), 64'h1);
      pop("t2.pop");
      check("t2.empty", 64'(ras_empty_o), 64'h1);
      check("t2.tos0", ras_pcdata_f0_o, 64'h0);

      // Overflow on the ninth push, then drain the stack.
      async_reset("t3.rst");
      for (int k = 1; k <= 9; k++) begin
         push("t3.push", 64'(k * 'h100));
         if (k == 8) check("t3.no_ovf", 64'(ras_ovf_o), 64'h0);
      end
      check("t3.ovf", 64'(ras_ovf_o), 64'h1);
      check("t3.cnt", 64'(ras_cnt_f1_o), 64'h8);
      for (int i = 0; i < 8; i++) begin
         check("t3.pop_val", ras_pcdata_f0_o, 64'((9 - i) * 'h100 + 4));
         pop("t3.pop");
         if (i == 0) check("t3.ovf_gone", 64'(ras_ovf_o), 64'h0);
      end
      check("t3.empty", 64'(ras_empty_o), 64'h1);
      ptr_save = ras_ptr_f1_o;
      cnt_save = ras_cnt_f1_o;
      pop("t3.underflow");
      check("t3.uf_ptr", 64'(ras_ptr_f1_o), 64'(ptr_save));
      check("t3.uf_cnt", 64'(ras_cnt_f1_o), 64'(cnt_save));

      // Pop-then-push replaces the top in place.
      async_reset("t4.rst");
      push("t4.push", 64'h1000);
      push("t4.push", 64'h2000);
      check("t4.tos_a", ras_pcdata_f0_o, 64'h2004);
      step("t4.pp", 1'b1, 1'b1, 3, 64'h3000, 1'b0, 0, 0, 64'h0);
      check("t4.tos_b", ras_pcdata_f0_o, 64'h3004);
      check("t4.cnt", 64'(ras_cnt_f1_o), 64'h2);
      check("t4.ptr", 64'(ras_ptr_f1_o), 64'h2);
      pop("t4.pop");
      check("t4.prev", ras_pcdata_f0_o, 64'h1004);

      // A flush beats a push in the same cycle.
      step("t5.flush", 1'b1, 1'b1, 1, 64'h7000, 1'b1, 5, 3, 64'hABC0);
      check("t5.tos", ras_pcdata_f0_o, 64'hABC0);
      check("t5.ptr", 64'(ras_ptr_f1_o), 64'h5);
      check("t5.cnt", 64'(ras_cnt_f1_o), 64'h3);

      // Gated pushes do nothing; the return address wraps modulo 2^64.
      step("t6.nobr", 1'b1, 1'b0, 1, 64'h8000, 1'b0, 0, 0, 64'h0);
      step("t6.novld", 1'b0, 1'b1, 1, 64'h8000, 1'b0, 0, 0, 64'h0);
      check("t6.hold", ras_pcdata_f0_o, 64'hABC0);
      push("t6.wrap", 64'hFFFF_FFFF_FFFF_FFFC);
      check("t6.wrap_tos", ras_pcdata_f0_o, 64'h0);
      check("t6.wrap_cnt", 64'(ras_cnt_f1_o), 64'h4);

      // Randomized phase with pushes favored so the full/overflow paths are hit.
      for (int n = 0; n < 1500; n++) begin
         int          ctl;
         logic [63:0] dat;
         int          sel;
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rnd.rst");
            continue;
         end
         sel = int'($urandom_range(0, 9));
         ctl = (sel < 4) ? 1 : (sel < 7) ? 2 : (sel < 9) ? 3 : 0;
         dat = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                            : {$urandom, $urandom};
         step("rnd",
              $urandom_range(0, 4) != 0,
              $urandom_range(0, 4) != 0,
              ctl, dat,
              $urandom_range(0, 19) == 0,
              int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, DEPTH)),
              {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
